// File: rtl/tdc_spi_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// tdc_arb_pkg
// Shared definitions for the TDC SPI arbiter slice: channel count, default
// widths and watchdog limit, the arbiter state encoding and the layout of the
// TDC command byte.
// ---------------------------------------------------------------------------
package tdc_arb_pkg;

   localparam int NUM_TDC                = 6;
   localparam int DEFAULT_DATA_W         = 24;
   localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

   // TDC command byte: [7] auto-increment, [6] write, [5:0] register address
   localparam int CMD_AUTOINC_BIT = 7;
   localparam int CMD_WRITE_BIT   = 6;
   localparam int CMD_ADDR_MSB    = 5;
   localparam int CMD_ADDR_LSB    = 0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LAUNCH  = 2'd1,
      WAIT    = 2'd2,
      RELEASE = 2'd3
   } arb_state_e;

   // A byte count of 0 is meaningless on the wire; it is sent as 1.
   function automatic logic [1:0] norm_len(input logic [1:0] len);
      return (len == 2'd0) ? 2'd1 : len;
   endfunction

endpackage

// File: rtl/tdc_spi_arbiter_if.sv
// ---------------------------------------------------------------------------
// tdc_spi_arbiter_if
// Bundles the channel-side request bus and the SPI-master handshake.
//   req/req_cmd/req_wdata/req_len : per-channel requests, lane i at [W*i +: W]
//   grant/ack/rdata/err           : per-channel grant, completion and result
//   spi_start/spi_cmd/spi_wdata/spi_len : launch of the shared SPI master
//   spi_done/spi_rdata            : completion from the SPI master
// Modports: master = the arbiter, slave = channels plus SPI master.
// ---------------------------------------------------------------------------
interface tdc_spi_arbiter_if
   import tdc_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_TDC,
   parameter int DATA_W  = DEFAULT_DATA_W
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*8-1:0]      req_cmd;
   logic [NUM_REQ*DATA_W-1:0] req_wdata;
   logic [NUM_REQ*2-1:0]      req_len;
   logic [NUM_REQ-1:0]        grant;
   logic [NUM_REQ-1:0]        ack;
   logic [DATA_W-1:0]         rdata;
   logic                      err;
   logic                      spi_start;
   logic [7:0]                spi_cmd;
   logic [DATA_W-1:0]         spi_wdata;
   logic [1:0]                spi_len;
   logic                      spi_done;
   logic [DATA_W-1:0]         spi_rdata;

   modport master (
      input  req, req_cmd, req_wdata, req_len, spi_done, spi_rdata,
      output grant, ack, rdata, err, spi_start, spi_cmd, spi_wdata, spi_len
   );

   modport slave (
      output req, req_cmd, req_wdata, req_len, spi_done, spi_rdata,
      input  grant, ack, rdata, err, spi_start, spi_cmd, spi_wdata, spi_len
   );
endinterface

// File: rtl/tdc_spi_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// tdc_rr_picker
// Combinational rotate-priority encoder. Picks the first set request bit
// scanning ptr+1, ptr+2, ... ptr+NUM_REQ (mod NUM_REQ), so the channel at
// ptr itself has the lowest priority.
//   req_i   : request vector
//   ptr_i   : index of the last channel served
//   found_o : any request set
//   k_o     : winning channel index (0 when found_o is low)
// ---------------------------------------------------------------------------
module tdc_rr_picker
   import tdc_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_TDC,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PTR_W-1:0]   ptr_i,
   output logic               found_o,
   output logic [PTR_W-1:0]   k_o
);

   always_comb begin
      int               idx;
      logic [PTR_W-1:0] idx_w;
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and infers a latch.
      found_o = 1'b0;
      k_o     = '0;
      idx     = 0;
      idx_w   = '0;
      // Scan from the farthest offset down: the last hit written is the
      // nearest one after ptr, which is the winner, without needing a break.
      for (int off = NUM_REQ; off >= 1; off--) begin
         idx   = (int'(ptr_i) + off) % NUM_REQ;
         idx_w = PTR_W'(idx);
         if (req_i[idx_w]) begin
            found_o = 1'b1;
            k_o     = idx_w;
         end
      end
   end

endmodule

// File: rtl/tdc_spi_arbiter.sv
// ---------------------------------------------------------------------------
// tdc_spi_arbiter
// Shares one SPI master among the TDC channel controllers. A round-robin
// arbiter grants one requester, latches its command/data/length, pulses
// spi_start, waits for spi_done and returns the read data with a one-cycle
// ack. Grant is held from arbitration through the ack cycle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : tdc_spi_arbiter_if.master (request bus and SPI handshake)
// Optional: define TDC_ARB_TIMEOUT_EN to build a WAIT watchdog of
// TIMEOUT_CYCLES that completes the transaction with err=1, rdata=0.
// Without it err is tied low and WAIT waits indefinitely.
// ---------------------------------------------------------------------------
module tdc_spi_arbiter
   import tdc_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_TDC,
   parameter int DATA_W  = DEFAULT_DATA_W
`ifdef TDC_ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
   input logic               clk,
   input logic               rst,
   tdc_spi_arbiter_if.master bus
);

   localparam int PTR_W = $clog2(NUM_REQ);

   localparam logic [1:0] S_IDLE    = IDLE;
   localparam logic [1:0] S_LAUNCH  = LAUNCH;
   localparam logic [1:0] S_WAIT    = WAIT;
   localparam logic [1:0] S_RELEASE = RELEASE;

   logic [1:0]         state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [PTR_W-1:0]   k_q, k_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;
   logic               spi_start_q, spi_start_d;
   logic [7:0]         spi_cmd_q, spi_cmd_d;
   logic [DATA_W-1:0]  spi_wdata_q, spi_wdata_d;
   logic [1:0]         spi_len_q, spi_len_d;

`ifdef TDC_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
`endif

   logic             pick_found;
   logic [PTR_W-1:0] pick_k;

   // Per-channel views of the packed request fields
   logic [7:0]        cmd_lane   [NUM_REQ];
   logic [DATA_W-1:0] wdata_lane [NUM_REQ];
   logic [1:0]        len_lane   [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
      assign cmd_lane[g]   = bus.req_cmd[8*g +: 8];
      assign wdata_lane[g] = bus.req_wdata[DATA_W*g +: DATA_W];
      assign len_lane[g]   = bus.req_len[2*g +: 2];
   end

   tdc_rr_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_picker (
      .req_i   (bus.req),
      .ptr_i   (ptr_q),
      .found_o (pick_found),
      .k_o     (pick_k)
   );

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      k_d         = k_q;
      grant_d     = grant_q;
      ack_d       = ack_q;
      rdata_d     = rdata_q;
      spi_start_d = spi_start_q;
      spi_cmd_d   = spi_cmd_q;
      spi_wdata_d = spi_wdata_q;
      spi_len_d   = spi_len_q;
`ifdef TDC_ARB_TIMEOUT_EN
      cnt_d       = cnt_q;
      err_d       = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               grant_d         = '0;
               grant_d[pick_k] = 1'b1;
               k_d             = pick_k;
               spi_cmd_d       = cmd_lane[pick_k];
               spi_wdata_d     = wdata_lane[pick_k];
               spi_len_d       = norm_len(len_lane[pick_k]);
               spi_start_d     = 1'b1;
               state_d         = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            // spi_done here cannot belong to this launch; it is ignored.
            spi_start_d = 1'b0;
            state_d     = S_WAIT;
`ifdef TDC_ARB_TIMEOUT_EN
            cnt_d       = '0;
`endif
         end
         S_WAIT: begin
            if (bus.spi_done) begin
               rdata_d     = bus.spi_rdata;
               ack_d       = '0;
               ack_d[k_q]  = 1'b1;
               state_d     = S_RELEASE;
`ifdef TDC_ARB_TIMEOUT_EN
               err_d       = 1'b0;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               rdata_d     = '0;
               ack_d       = '0;
               ack_d[k_q]  = 1'b1;
               err_d       = 1'b1;
               state_d     = S_RELEASE;
            end else begin
               cnt_d       = cnt_q + 1'b1;
`endif
            end
         end
         S_RELEASE: begin
            // req is not sampled here so the owner has a cycle to drop it.
            ack_d   = '0;
            grant_d = '0;
            ptr_d   = k_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ptr_q       <= PTR_W'(NUM_REQ - 1);
         k_q         <= '0;
         grant_q     <= '0;
         ack_q       <= '0;
         rdata_q     <= '0;
         spi_start_q <= 1'b0;
         spi_cmd_q   <= '0;
         spi_wdata_q <= '0;
         spi_len_q   <= '0;
`ifdef TDC_ARB_TIMEOUT_EN
         cnt_q       <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         k_q         <= k_d;
         grant_q     <= grant_d;
         ack_q       <= ack_d;
         rdata_q     <= rdata_d;
         spi_start_q <= spi_start_d;
         spi_cmd_q   <= spi_cmd_d;
         spi_wdata_q <= spi_wdata_d;
         spi_len_q   <= spi_len_d;
`ifdef TDC_ARB_TIMEOUT_EN
         cnt_q       <= cnt_d;
         err_q       <= err_d;
`endif
      end
   end

   assign bus.grant     = grant_q;
   assign bus.ack       = ack_q;
   assign bus.rdata     = rdata_q;
   assign bus.spi_start = spi_start_q;
   assign bus.spi_cmd   = spi_cmd_q;
   assign bus.spi_wdata = spi_wdata_q;
   assign bus.spi_len   = spi_len_q;
`ifdef TDC_ARB_TIMEOUT_EN
   assign bus.err       = err_q;
`else
   assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_tdc_spi_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tdc_spi_arbiter
// Self-checking bench for tdc_spi_arbiter: a table of single transactions,
// hand-written corner sequences and randomized traffic checked against a
// round-robin reference model. Inputs change and outputs are sampled on the
// falling clock edge. With TDC_ARB_TIMEOUT_EN the DUT is built with a
// 16-cycle watchdog and the timeout sequences run as well.
// ---------------------------------------------------------------------------
module tb_tdc_spi_arbiter;
   import tdc_arb_pkg::*;

   localparam int N           = NUM_TDC;
   localparam int DW          = 24;
   localparam int WATCHDOG_NS = 100 * DEFAULT_TIMEOUT_CYCLES;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   tdc_spi_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

`ifdef TDC_ARB_TIMEOUT_EN
   tdc_spi_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT_CYCLES(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
`else
   tdc_spi_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
`endif

   int checks = 0;
   int errors = 0;
   int m_ptr;     // model: index of the channel served last

   typedef struct {
      logic [5:0]  mask;
      logic [7:0]  cmd;
      logic [23:0] wdata;
      logic [1:0]  len;
      logic [23:0] rd;
      int          exp_ch;
      logic [1:0]  exp_len;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Round-robin rule: first requester after the last one served.
   function automatic int pick(input logic [5:0] mask, input int ptr);
      for (int off = 1; off <= N; off++) begin
         if (mask[3'((ptr + off) % N)]) return (ptr + off) % N;
      end
      return -1;
   endfunction

   function automatic logic [7:0] mk_cmd(input bit autoinc, input bit wr, input logic [5:0] addr);
      logic [7:0] c;
      c = '0;
      c[CMD_AUTOINC_BIT]             = autoinc;
      c[CMD_WRITE_BIT]               = wr;
      c[CMD_ADDR_MSB:CMD_ADDR_LSB]   = addr;
      return c;
   endfunction

   function automatic logic [5:0] onehot(input int ch);
      logic [5:0] v;
      v = '0;
      v[3'(ch)] = 1'b1;
      return v;
   endfunction

   task automatic set_lane(input int c, input logic [7:0] cmd, input logic [23:0] wd, input logic [1:0] len);
      bus.req_cmd[8*c +: 8]     = cmd;
      bus.req_wdata[DW*c +: DW] = wd;
      bus.req_len[2*c +: 2]     = len;
   endtask

   task automatic scramble_lanes();
      for (int c = 0; c < N; c++)
         set_lane(c, 8'($urandom), 24'($urandom), 2'($urandom));
   endtask

   task automatic do_reset(input bit do_checks);
      rst           = 1'b1;
      bus.req       = '0;
      bus.req_cmd   = '0;
      bus.req_wdata = '0;
      bus.req_len   = '0;
      bus.spi_done  = 1'b0;
      bus.spi_rdata = '0;
      @(negedge clk);
      @(negedge clk);
      if (do_checks) begin
         check("rst_grant",     32'(bus.grant),     0);
         check("rst_ack",       32'(bus.ack),       0);
         check("rst_rdata",     32'(bus.rdata),     0);
         check("rst_err",       32'(bus.err),       0);
         check("rst_spi_start", 32'(bus.spi_start), 0);
         check("rst_spi_cmd",   32'(bus.spi_cmd),   0);
         check("rst_spi_wdata", 32'(bus.spi_wdata), 0);
         check("rst_spi_len",   32'(bus.spi_len),   0);
      end
      rst   = 1'b0;
      m_ptr = N - 1;
   endtask

   // Returns the number of falling edges until spi_start is seen, -1 if never.
   task automatic wait_start(output int n);
      n = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.spi_start) begin
            n = i;
            break;
         end
      end
      if (n < 0) check("spi_start_seen", 32'(bus.spi_start), 1);
   endtask

   // One complete transaction: grant, latched fields, done after `delay`
   // WAIT cycles, ack/rdata, release. req is set to req_after in the ack cycle.
   task automatic run_txn(input int exp_ch, input logic [7:0] e_cmd, input logic [23:0] e_wd,
                          input logic [1:0] e_len, input logic [23:0] rd, input int delay,
                          input logic [5:0] req_after, input int exp_lat);
      int n;
      wait_start(n);
      if (n < 0) return;
      if (exp_lat > 0) check("grant_latency", n, exp_lat);
      check("grant",     32'(bus.grant),     32'(onehot(exp_ch)));
      check("spi_cmd",   32'(bus.spi_cmd),   32'(e_cmd));
      check("spi_wdata", 32'(bus.spi_wdata), 32'(e_wd));
      check("spi_len",   32'(bus.spi_len),   32'(e_len));
      check("ack_early", 32'(bus.ack),       0);
      repeat (delay) @(negedge clk);
      check("spi_start_pulse", 32'(bus.spi_start), 0);
      bus.spi_done  = 1'b1;
      bus.spi_rdata = rd;
      @(negedge clk);
      bus.spi_done  = 1'b0;
      bus.spi_rdata = 24'($urandom);
      check("ack",        32'(bus.ack),   32'(onehot(exp_ch)));
      check("rdata",      32'(bus.rdata), 32'(rd));
      check("err",        32'(bus.err),   0);
      check("grant_held", 32'(bus.grant), 32'(onehot(exp_ch)));
      bus.req = req_after;
      @(negedge clk);
      check("ack_cleared",   32'(bus.ack),   0);
      check("grant_cleared", 32'(bus.grant), 0);
      m_ptr = exp_ch;
   endtask

   initial begin
      #(WATCHDOG_NS);
      $display("FAIL watchdog: simulation exceeded %0d ns", WATCHDOG_NS);
      $fatal(1);
   end

   initial begin
      int n;
      int cnt;
      logic [5:0]  mask;
      logic [7:0]  cmd;
      logic [23:0] wd;
      logic [1:0]  len;
      int          ch;

      // mask, cmd, wdata, len, rd, exp_ch, exp_len
      vecs[0] = '{6'b000001, mk_cmd(0, 1, 6'd1),  24'h000002, 2'd1, 24'h0000AB, 0, 2'd1};
      vecs[1] = '{6'b100100, mk_cmd(1, 0, 6'd12), 24'h00ABCD, 2'd2, 24'h123456, 2, 2'd2};
      vecs[2] = '{6'b100100, mk_cmd(0, 0, 6'd63), 24'hFFFFFF, 2'd3, 24'hFEDCBA, 5, 2'd3};
      vecs[3] = '{6'b001000, mk_cmd(0, 1, 6'd7),  24'h5A5A5A, 2'd0, 24'h000001, 3, 2'd1};
      vecs[4] = '{6'b111111, mk_cmd(1, 1, 6'd0),  24'h010203, 2'd3, 24'h800000, 4, 2'd3};
      vecs[5] = '{6'b000011, mk_cmd(0, 0, 6'd33), 24'h000000, 2'd1, 24'h00FF00, 0, 2'd1};
      vecs[6] = '{6'b000001, mk_cmd(1, 0, 6'd5),  24'hC0FFEE, 2'd2, 24'h0BEEF0, 0, 2'd2};
      vecs[7] = '{6'b100000, mk_cmd(0, 1, 6'd40), 24'h777777, 2'd0, 24'h999999, 5, 2'd1};

      do_reset(1'b1);

      // Table: one transaction per row, requests dropped at ack.
      for (int i = 0; i < 8; i++) begin
         scramble_lanes();
         set_lane(vecs[i].exp_ch, vecs[i].cmd, vecs[i].wdata, vecs[i].len);
         bus.req = vecs[i].mask;
         run_txn(vecs[i].exp_ch, vecs[i].cmd, vecs[i].wdata, vecs[i].exp_len,
                 vecs[i].rd, 1 + i % 3, 6'b0, 1);
      end

      // All six held: grants 0..5,0, next grant exactly 2 cycles after ack.
      do_reset(1'b0);
      for (int c = 0; c < N; c++)
         set_lane(c, mk_cmd(0, 1, 6'(c)), 24'(c * 24'h111111), 2'(c % 4));
      bus.req = 6'b111111;
      for (int j = 0; j < 7; j++) begin
         ch = j % N;
         run_txn(ch, mk_cmd(0, 1, 6'(ch)), 24'(ch * 24'h111111),
                 (ch % 4 == 0) ? 2'd1 : 2'(ch % 4), 24'(24'h100 + j), 1,
                 (j == 6) ? 6'b0 : 6'b111111, 1);
      end

      // Fairness: 2 and 5 held; 2 re-requests yet 5 goes first.
      do_reset(1'b0);
      set_lane(2, 8'h22, 24'h222222, 2'd2);
      set_lane(5, 8'h55, 24'h555555, 2'd3);
      bus.req = 6'b100100;
      run_txn(2, 8'h22, 24'h222222, 2'd2, 24'hA2, 2, 6'b100100, 1);
      run_txn(5, 8'h55, 24'h555555, 2'd3, 24'hA5, 1, 6'b100100, 1);
      run_txn(2, 8'h22, 24'h222222, 2'd2, 24'hB2, 1, 6'b000000, 1);

      // Len 0 -> 1, fields not re-sampled, req dropped after grant,
      // spi_done in LAUNCH ignored, a short req pulse never sampled.
      do_reset(1'b0);
      set_lane(3, 8'hC5, 24'h123456, 2'd0);
      bus.req = 6'b001000;
      wait_start(n);
      check("lat_grant",   32'(bus.grant),   32'(6'b001000));
      check("lat_len0",    32'(bus.spi_len), 1);
      bus.req       = 6'b0;
      set_lane(3, 8'h3A, 24'h654321, 2'd3);
      bus.spi_done  = 1'b1;
      bus.spi_rdata = 24'hDEAD00;
      @(negedge clk);
      bus.spi_done  = 1'b0;
      check("launch_done_ignored", 32'(bus.ack),       0);
      check("lat_cmd_kept",        32'(bus.spi_cmd),   32'(8'hC5));
      check("lat_wdata_kept",      32'(bus.spi_wdata), 32'(24'h123456));
      check("lat_len_kept",        32'(bus.spi_len),   1);
      bus.req[1] = 1'b1;
      @(negedge clk);
      bus.req[1] = 1'b0;
      @(negedge clk);
      bus.spi_done  = 1'b1;
      bus.spi_rdata = 24'h0000C3;
      @(negedge clk);
      bus.spi_done  = 1'b0;
      check("drop_ack",   32'(bus.ack),   32'(6'b001000));
      check("drop_rdata", 32'(bus.rdata), 32'(24'h0000C3));
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus.spi_start) cnt++;
      end
      check("no_spurious_start", cnt, 0);
      m_ptr = 3;

      // Reset in WAIT: outputs clear, no ack, pointer restored.
      do_reset(1'b0);
      set_lane(0, 8'h10, 24'h000010, 2'd1);
      set_lane(1, 8'h11, 24'h000011, 2'd2);
      bus.req = 6'b000001;
      run_txn(0, 8'h10, 24'h000010, 2'd1, 24'h0000F0, 1, 6'b000010, 1);
      run_txn(1, 8'h11, 24'h000011, 2'd2, 24'h0000F1, 1, 6'b000010, 1);
      wait_start(n);
      check("rst_wait_grant_pre", 32'(bus.grant), 32'(6'b000010));
      @(negedge clk);
      rst           = 1'b1;
      bus.spi_done  = 1'b1;
      bus.spi_rdata = 24'hBAD000;
      @(negedge clk);
      bus.spi_done = 1'b0;
      check("rst_wait_grant", 32'(bus.grant),     0);
      check("rst_wait_ack",   32'(bus.ack),       0);
      check("rst_wait_start", 32'(bus.spi_start), 0);
      check("rst_wait_rdata", 32'(bus.rdata),     0);
      rst     = 1'b0;
      m_ptr   = N - 1;
      bus.req = 6'b000011;
      run_txn(pick(6'b000011, m_ptr), 8'h10, 24'h000010, 2'd1, 24'h0000F2, 1, 6'b0, 1);

      // Randomized traffic against the round-robin model.
      do_reset(1'b0);
      for (int t = 0; t < 40; t++) begin
         mask = (t % 7 == 3) ? 6'b0 : 6'($urandom_range(1, 63));
         if (mask == 6'b0) begin
            bus.req = 6'b0;
            cnt = 0;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               if (bus.spi_start) cnt++;
            end
            check("rand_idle_no_start", cnt, 0);
         end else begin
            ch  = pick(mask, m_ptr);
            cmd = 8'($urandom);
            wd  = 24'($urandom);
            len = 2'($urandom);
            scramble_lanes();
            set_lane(ch, cmd, wd, len);
            bus.req = mask;
            run_txn(ch, cmd, wd, (len == 2'd0) ? 2'd1 : len, 24'($urandom),
                    $urandom_range(1, 5), 6'b0, 1);
         end
      end

`ifdef TDC_ARB_TIMEOUT_EN
      // Watchdog: no spi_done -> ack with err after 16 WAIT cycles.
      do_reset(1'b0);
      set_lane(4, 8'h44, 24'h444444, 2'd1);
      bus.req = 6'b010000;
      wait_start(n);
      bus.req = 6'b0;
      cnt = 0;
      while (cnt < 40 && bus.ack == 6'b0) begin
         @(negedge clk);
         cnt++;
      end
      check("to_latency", cnt, 17);
      check("to_ack",     32'(bus.ack),   32'(6'b010000));
      check("to_err",     32'(bus.err),   1);
      check("to_rdata",   32'(bus.rdata), 0);
      @(negedge clk);
      m_ptr = 4;

      // spi_done on the 16th WAIT cycle beats the timeout.
      bus.req = 6'b010000;
      wait_start(n);
      bus.req = 6'b0;
      repeat (16) @(negedge clk);
      check("to_edge_no_early_ack", 32'(bus.ack), 0);
      bus.spi_done  = 1'b1;
      bus.spi_rdata = 24'h00BEEF;
      @(negedge clk);
      bus.spi_done = 1'b0;
      check("to_edge_ack",   32'(bus.ack),   32'(6'b010000));
      check("to_edge_err",   32'(bus.err),   0);
      check("to_edge_rdata", 32'(bus.rdata), 32'(24'h00BEEF));
      @(negedge clk);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tdc_spi_arbiter.md
Name: tdc_spi_arbiter

Overview:
- Shares one SPI master among the six TDC channel controllers (f1..f6).
- Each controller posts a register transaction: a command byte plus write data.
- A round-robin arbiter grants one controller, launches the SPI master, waits for completion, and returns read data with a one-cycle ack.
- Sits between the per-channel TDC sequencers, which act after enable and soft reset, and the single SPI master that drives the shared bus.

Parameters:
- NUM_REQ, 6, number of requesting TDC channels.
- DATA_W, 24, SPI data field width; 24 covers the widest TDC result register.
- TIMEOUT_CYCLES, 4096, watchdog limit in WAIT. Used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req  in  NUM_REQ  level request per channel; held until that channel's ack
- req_cmd  in  NUM_REQ*8  per-channel command byte; channel i occupies bits [8i+7:8i]
- req_wdata  in  NUM_REQ*DATA_W  per-channel write data, packed the same way
- req_len  in  NUM_REQ*2  per-channel data byte count, 1..3; a value of 0 is treated as 1
- grant  out  NUM_REQ  one-hot; held from grant through ack; also selects chip-select
- ack  out  NUM_REQ  one-cycle completion pulse to the owning channel
- rdata  out  DATA_W  read data; valid only in the ack cycle
- err  out  1  timeout flag; valid with ack
- spi_start  out  1  one-cycle launch pulse to the SPI master
- spi_cmd  out  8  latched command byte
- spi_wdata  out  DATA_W  latched write data
- spi_len  out  2  latched byte count, already normalised (0 becomes 1)
- spi_done  in  1  one-cycle completion pulse from the SPI master
- spi_rdata  in  DATA_W  SPI master read data; valid with spi_done

Behaviour:
- Reset values:
  - state=IDLE, grant=0, ack=0, rdata=0, err=0, spi_start=0, spi_cmd/spi_wdata/spi_len=0.
  - Priority pointer ptr=NUM_REQ-1, so channel 0 wins the first arbitration.
- All outputs are registered.

FSM, four states:
- IDLE: if any req bit is set, select winner k, the first set bit scanning ptr+1, ptr+2, ... ptr+NUM_REQ (mod NUM_REQ). On that edge:
  - grant <= one-hot(k)
  - latch req_cmd/req_wdata/req_len of channel k into spi_* (len 0 becomes 1)
  - spi_start <= 1
  - next state LAUNCH
  - If no req bit is set, stay in IDLE.
- LAUNCH: spi_start is high for exactly this one cycle, then cleared. Next state WAIT. spi_done in this cycle is ignored.
- WAIT: on spi_done:
  - rdata <= spi_rdata
  - ack[k] <= 1
  - err <= 0
  - next state RELEASE
- RELEASE: ack pulse visible this cycle. On exit:
  - ack <= 0
  - grant <= 0
  - ptr <= k
  - next state IDLE
  - req is not sampled in RELEASE, which gives the requester one cycle to drop req.

Timing and ordering:
- Latency: req seen in IDLE at cycle T → grant and spi_start high at T+1.
- spi_done at cycle D → ack high at D+1.
- Back-to-back: the next grant appears no earlier than 2 cycles after ack.
- Fairness: a channel that was just served has the lowest priority in the next arbitration. Worst-case wait is NUM_REQ-1 transactions.

Boundary conditions:
- req dropped after grant: the transaction completes anyway and ack still pulses.
- req dropped before the grant edge: no transaction is issued.
- Latched fields are not re-sampled: changes to req_* after grant have no effect.
- rst mid-transaction: return to reset values immediately, with no ack and no further spi_start. The SPI master shares the same rst.
- Requests arriving in the same cycle are resolved purely by ptr order.

Optional Feature:
- Macro: TDC_ARB_TIMEOUT_EN.
- When defined:
  - A counter of $clog2(TIMEOUT_CYCLES) bits is cleared on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES-1 with no spi_done: ack[k]<=1, err<=1, rdata<=0, next state RELEASE.
  - If spi_done and the timeout occur in the same cycle, spi_done wins (err=0).
- When not defined: no counter is built, err is tied 0, and WAIT waits indefinitely.

Decomposition:
- Package tdc_arb_pkg:
  - state enum {IDLE, LAUNCH, WAIT, RELEASE}
  - NUM_TDC=6
  - TDC command-byte constants: CMD_AUTOINC bit7, CMD_WRITE bit6, CMD_ADDR_MSB/LSB 5:0
  - default TIMEOUT_CYCLES
- Sub-module tdc_rr_picker: combinational rotate-priority encoder. Inputs req and ptr; outputs found and k.

Test Plan:
- Reset, then req=6'b000001, cmd=8'h41, wdata=24'h000002, len=1 → grant=000001 and spi_start at T+1; spi_cmd=8'h41, spi_len=1; spi_done with rdata=24'h0000AB → ack[0] one cycle later, rdata=24'h0000AB.
- All six req bits held high → grants in order 0,1,2,3,4,5,0, each released before the next; no overlap of grant bits.
- Channels 2 and 5 request, channel 2 is served, channel 2 re-requests immediately → channel 5 is granted before channel 2's second transaction.
- req_len=0 on channel 3 → spi_len=1. Changing req_cmd after grant → spi_cmd is unchanged.
- Assert rst while in WAIT → the next cycle shows grant=0, ack=0, spi_start=0 and ptr restored (channel 0 wins next).
- With TDC_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, withhold spi_done → ack with err=1 and rdata=0 after 16 WAIT cycles. spi_done on cycle 16 → err=0.
